// File: rtl/irq_controller.sv
// 16-source interrupt controller: pending/enable/group-priority registers, arbitration vs cpu_level, frozen req/ack handshake.
// Latency: strobe on ce edge k -> irq_req after k+1; no backpressure, the CPU paces via irq_ack.
module irq_controller #(
  parameter logic [23:0] IRQ_PRI = 24'h2020,
  parameter logic [23:0] IRQ_ENA = 24'h2023,
  parameter logic [23:0] IRQ_ACT = 24'h2027
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce_cpu,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic [15:0] irq_in,
  input  logic [1:0]  cpu_level,
  input  logic        irq_ack,
  output logic        irq_req,
  output logic [3:0]  irq_vector,
  output logic [1:0]  irq_level
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_pri;
  logic [15:0] r_ena, r_pend;
  logic [3:0]  r_vector, w_vector_nxt;
  logic [1:0]  r_level, w_level_nxt;
  logic [15:0] w_elig, w_clr;
  logic        w_any;
  logic [3:0]  w_win_idx;
  logic [1:0]  w_win_pri;
  logic        w_wr_pri, w_wr_ena_l, w_wr_ena_h, w_wr_act_l, w_wr_act_h;
  logic        w_unused_rd;

  assign w_unused_rd = bus_read;

  assign w_wr_pri   = bus_write && (bus_address_in == IRQ_PRI);
  assign w_wr_ena_l = bus_write && (bus_address_in == IRQ_ENA);
  assign w_wr_ena_h = bus_write && (bus_address_in == IRQ_ENA + 24'd1);
  assign w_wr_act_l = bus_write && (bus_address_in == IRQ_ACT);
  assign w_wr_act_h = bus_write && (bus_address_in == IRQ_ACT + 24'd1);

  assign w_clr = {(w_wr_act_h ? bus_data_in : 8'h00), (w_wr_act_l ? bus_data_in : 8'h00)};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pri  <= 8'h00;
      r_ena  <= 16'h0000;
      r_pend <= 16'h0000;
    end else if (clk_ce_cpu) begin
      if (w_wr_pri)   r_pri       <= bus_data_in;
      if (w_wr_ena_l) r_ena[7:0]  <= bus_data_in;
      if (w_wr_ena_h) r_ena[15:8] <= bus_data_in;
      // OR-ing the strobe after the clear makes a simultaneous set win
      r_pend <= (r_pend & ~w_clr) | irq_in;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_elig[i] = r_pend[i] && r_ena[i] && (r_pri[2*(i/4) +: 2] > cpu_level);
    end
  end

  // Descending scan with >= lets lower indices win ties within and across groups
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = 4'd0;
    w_win_pri = 2'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_elig[i] && (r_pri[2*(i/4) +: 2] >= w_win_pri)) begin
        w_any     = 1'b1;
        w_win_idx = 4'(i);
        w_win_pri = r_pri[2*(i/4) +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_vector <= 4'd0;
      r_level  <= 2'd0;
    end else if (clk_ce_cpu) begin
      r_state  <= w_state_nxt;
      r_vector <= w_vector_nxt;
      r_level  <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_vector_nxt = r_vector;
    w_level_nxt  = r_level;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt  = S_REQ;
          w_vector_nxt = w_win_idx;
          w_level_nxt  = w_win_pri;
        end
      end
      S_REQ: begin
        if (irq_ack)                w_state_nxt = S_HOLD;
        else if (!w_elig[r_vector]) w_state_nxt = S_IDLE;
      end
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign irq_req    = (r_state == S_REQ);
  assign irq_vector = r_vector;
  assign irq_level  = r_level;

  always_comb begin
    bus_data_out = 8'h00;
    if (bus_address_in == IRQ_PRI)              bus_data_out = r_pri;
    else if (bus_address_in == IRQ_ENA)         bus_data_out = r_ena[7:0];
    else if (bus_address_in == IRQ_ENA + 24'd1) bus_data_out = r_ena[15:8];
    else if (bus_address_in == IRQ_ACT)         bus_data_out = r_pend[7:0];
    else if (bus_address_in == IRQ_ACT + 24'd1) bus_data_out = r_pend[15:8];
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: hand-derived vector table, corner sequences, then random traffic vs a reference model.
module tb_irq_controller;

  localparam int A_PRI  = 'h2020;
  localparam int A_ENAL = 'h2023;
  localparam int A_ENAH = 'h2024;
  localparam int A_ACTL = 'h2027;
  localparam int A_ACTH = 'h2028;

  logic        clk = 1'b0;
  logic        reset, clk_ce_cpu, bus_write, bus_read, irq_ack, irq_req;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in, bus_data_out;
  logic [15:0] irq_in;
  logic [1:0]  cpu_level, irq_level;
  logic [3:0]  irq_vector;

  int checks = 0;
  int errors = 0;

  irq_controller dut (
    .clk(clk), .reset(reset), .clk_ce_cpu(clk_ce_cpu), .bus_write(bus_write),
    .bus_read(bus_read), .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .irq_in(irq_in), .cpu_level(cpu_level),
    .irq_ack(irq_ack), .irq_req(irq_req), .irq_vector(irq_vector), .irq_level(irq_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  dat;
    logic [15:0] irq;
    logic [1:0]  cpu;
    logic        ack;
    logic        req;
    logic [3:0]  vec;
    logic [1:0]  lvl;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int wr, input int a, input int d, input int irq, input int cpu,
                     input int ack, input int req, input int vec, input int lvl, input int rd);
    vec_t v;
    v.wr = 1'(wr); v.addr = 24'(a); v.dat = 8'(d); v.irq = 16'(irq); v.cpu = 2'(cpu);
    v.ack = 1'(ack); v.req = 1'(req); v.vec = 4'(vec); v.lvl = 2'(lvl); v.rd = 8'(rd);
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  // Reference model: per-group priorities and per-source flags as plain arrays
  int       m_gpri[4];
  bit [15:0] m_ena, m_pend;
  bit       m_req, m_hold;
  int       m_vec, m_lvl;

  function automatic bit m_elig(input int i);
    return m_pend[i] && m_ena[i] && (m_gpri[i/4] > int'(cpu_level));
  endfunction

  function automatic int m_winner();
    for (int p = 3; p >= 1; p--)
      for (int i = 0; i < 16; i++)
        if (m_gpri[i/4] == p && m_elig(i)) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    case (a)
      A_PRI:   return 8'(m_gpri[0] | (m_gpri[1] << 2) | (m_gpri[2] << 4) | (m_gpri[3] << 6));
      A_ENAL:  return m_ena[7:0];
      A_ENAH:  return m_ena[15:8];
      A_ACTL:  return m_pend[7:0];
      A_ACTH:  return m_pend[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    for (int g = 0; g < 4; g++) m_gpri[g] = 0;
    m_ena = '0; m_pend = '0; m_req = 0; m_hold = 0; m_vec = 0; m_lvl = 0;
  endtask

  task automatic m_step();
    int w;
    w = m_winner();
    if (m_hold) m_hold = 0;
    else if (m_req) begin
      if (irq_ack) begin m_req = 0; m_hold = 1; end
      else if (!m_elig(m_vec)) m_req = 0;
    end else if (w >= 0) begin
      m_req = 1; m_vec = w; m_lvl = m_gpri[w/4];
    end
    if (bus_write) begin
      case (int'(bus_address_in))
        A_PRI:  for (int g = 0; g < 4; g++) m_gpri[g] = (int'(bus_data_in) >> (2*g)) & 3;
        A_ENAL: m_ena[7:0] = bus_data_in;
        A_ENAH: m_ena[15:8] = bus_data_in;
        A_ACTL: m_pend[7:0] = m_pend[7:0] & ~bus_data_in;
        A_ACTH: m_pend[15:8] = m_pend[15:8] & ~bus_data_in;
        default: ;
      endcase
    end
    m_pend = m_pend | irq_in;
  endtask

  int rnd_addr[7] = '{A_PRI, A_ENAL, A_ENAH, A_ACTL, A_ACTH, 'h2021, 'h012027};

  initial begin
    reset = 1; clk_ce_cpu = 1; bus_write = 0; bus_read = 0; irq_ack = 0;
    bus_address_in = 24'(A_PRI); bus_data_in = 0; irq_in = 0; cpu_level = 0;
    step(); step();
    chk("rst_req", 0, 16'(irq_req), 0);
    chk("rst_vec", 0, 16'(irq_vector), 0);
    chk("rst_lvl", 0, 16'(irq_level), 0);
    chk("rst_pri", 0, 16'(bus_data_out), 0);
    reset = 0;

    //   wr addr    dat    irq       cpu ack  req vec lvl rd
    add(1, A_PRI,  'h03, 0,        0, 0,   0, 0,  0, 'h03);
    add(1, A_ENAL, 'h01, 0,        0, 0,   0, 0,  0, 'h01);
    add(0, A_ACTL, 0,    'h0001,   0, 0,   0, 0,  0, 'h01);
    add(0, A_ACTL, 0,    0,        0, 0,   1, 0,  3, 'h01);
    add(1, A_ACTL, 'h01, 0,        0, 0,   1, 0,  3, 'h00);
    add(0, A_ACTL, 0,    0,        0, 0,   0, 0,  3, 'h00);
    add(1, A_PRI,  'h79, 0,        0, 0,   0, 0,  3, 'h79);
    add(1, A_ENAL, 'hFF, 0,        0, 0,   0, 0,  3, 'hFF);
    add(1, A_ENAH, 'hFF, 0,        0, 0,   0, 0,  3, 'hFF);
    add(0, A_ACTH, 0,    'h2222,   0, 0,   0, 0,  3, 'h22);
    add(0, A_ACTL, 0,    0,        0, 0,   1, 9,  3, 'h22);
    add(0, A_ACTL, 0,    0,        0, 1,   0, 9,  3, 'h22);
    add(1, A_ACTH, 'h02, 0,        0, 0,   0, 9,  3, 'h20);
    add(0, A_ACTH, 0,    0,        0, 0,   1, 5,  2, 'h20);
    add(0, A_ACTH, 0,    0,        0, 1,   0, 5,  2, 'h20);
    add(1, A_ACTL, 'h20, 0,        0, 0,   0, 5,  2, 'h02);
    add(0, A_ACTL, 0,    0,        0, 0,   1, 1,  1, 'h02);
    add(0, A_ACTL, 0,    0,        0, 1,   0, 1,  1, 'h02);
    add(1, A_ACTL, 'h02, 0,        0, 0,   0, 1,  1, 'h00);
    add(0, A_ACTH, 0,    0,        0, 0,   1, 13, 1, 'h20);
    add(0, A_ACTH, 0,    0,        0, 1,   0, 13, 1, 'h20);
    add(1, A_ACTH, 'h20, 0,        0, 0,   0, 13, 1, 'h00);
    add(0, A_ACTH, 0,    0,        0, 0,   0, 13, 1, 'h00);
    add(0, A_ACTL, 0,    'h0010,   2, 0,   0, 13, 1, 'h10);
    add(0, A_ACTL, 0,    0,        2, 0,   0, 13, 1, 'h10);
    add(0, A_ACTL, 0,    0,        1, 0,   1, 4,  2, 'h10);
    add(0, A_ACTL, 0,    0,        1, 1,   0, 4,  2, 'h10);
    add(1, A_ACTL, 'h10, 0,        1, 0,   0, 4,  2, 'h00);
    add(1, A_ENAL, 'h00, 0,        0, 0,   0, 4,  2, 'h00);
    add(0, A_ACTL, 0,    'h0080,   0, 0,   0, 4,  2, 'h80);
    add(0, A_ACTL, 0,    0,        0, 0,   0, 4,  2, 'h80);
    add(1, A_ENAL, 'h80, 0,        0, 0,   0, 4,  2, 'h80);
    add(0, A_ACTL, 0,    0,        0, 0,   1, 7,  2, 'h80);
    add(0, A_ACTL, 0,    0,        0, 1,   0, 7,  2, 'h80);
    add(1, A_ACTL, 'h80, 0,        0, 0,   0, 7,  2, 'h00);
    add(1, A_ENAL, 'h08, 0,        0, 0,   0, 7,  2, 'h08);
    add(0, A_ACTL, 0,    'h0008,   0, 0,   0, 7,  2, 'h08);
    add(0, A_ACTL, 0,    0,        0, 0,   1, 3,  1, 'h08);
    add(1, A_ACTL, 'h08, 0,        0, 0,   1, 3,  1, 'h00);
    add(0, A_ACTL, 0,    0,        0, 0,   0, 3,  1, 'h00);
    add(1, A_ACTL, 'h08, 'h0008,   0, 0,   0, 3,  1, 'h08);
    add(0, A_ACTL, 0,    0,        0, 0,   1, 3,  1, 'h08);
    add(0, A_ACTL, 0,    0,        0, 1,   0, 3,  1, 'h08);
    add(0, A_ACTL, 0,    0,        0, 0,   0, 3,  1, 'h08);
    add(0, A_ACTL, 0,    0,        0, 0,   1, 3,  1, 'h08);
    add(1, A_ACTL, 'h08, 0,        0, 0,   1, 3,  1, 'h00);
    add(0, A_ACTL, 0,    0,        0, 1,   0, 3,  1, 'h00);
    add(0, A_ACTL, 0,    0,        0, 0,   0, 3,  1, 'h00);

    for (int r = 0; r < tbl.size(); r++) begin
      bus_write = tbl[r].wr; bus_address_in = tbl[r].addr; bus_data_in = tbl[r].dat;
      irq_in = tbl[r].irq; cpu_level = tbl[r].cpu; irq_ack = tbl[r].ack;
      step();
      chk("tbl_req", r, 16'(irq_req), 16'(tbl[r].req));
      chk("tbl_vec", r, 16'(irq_vector), 16'(tbl[r].vec));
      chk("tbl_lvl", r, 16'(irq_level), 16'(tbl[r].lvl));
      chk("tbl_rd", r, 16'(bus_data_out), 16'(tbl[r].rd));
    end
    bus_write = 0; irq_ack = 0; irq_in = 0; cpu_level = 0;

    // Reset while a request is outstanding
    irq_in = 16'h0008; step();
    irq_in = 16'h0000; step();
    chk("pre_rst_req", 0, 16'(irq_req), 1);
    reset = 1; step();
    chk("mid_rst_req", 0, 16'(irq_req), 0);
    chk("mid_rst_vec", 0, 16'(irq_vector), 0);
    chk("mid_rst_lvl", 0, 16'(irq_level), 0);
    bus_address_in = 24'(A_ACTL); #1;
    chk("mid_rst_act", 0, 16'(bus_data_out), 0);
    reset = 0;

    // Edges without clk_ce_cpu must not change anything
    clk_ce_cpu = 0; irq_in = 16'hFFFF; bus_write = 1;
    bus_address_in = 24'(A_PRI); bus_data_in = 8'hFF;
    step(); step();
    chk("noce_pri", 0, 16'(bus_data_out), 0);
    bus_address_in = 24'(A_ACTL); #1;
    chk("noce_act", 0, 16'(bus_data_out), 0);
    chk("noce_req", 0, 16'(irq_req), 0);
    clk_ce_cpu = 1; irq_in = 0; bus_write = 0;

    // Randomized traffic against the model
    reset = 1; step(); reset = 0; m_reset();
    for (int n = 0; n < 4000; n++) begin
      clk_ce_cpu     = ($urandom_range(0, 3) != 0);
      bus_write      = ($urandom_range(0, 3) == 0);
      bus_address_in = 24'(rnd_addr[$urandom_range(0, 6)]);
      bus_data_in    = 8'($urandom);
      irq_in         = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) cpu_level = 2'($urandom);
      irq_ack        = ($urandom_range(0, 2) == 0);
      if (clk_ce_cpu) m_step();
      step();
      chk("rnd_req", n, 16'(irq_req), 16'(m_req));
      chk("rnd_vec", n, 16'(irq_vector), 16'(m_vec));
      chk("rnd_lvl", n, 16'(irq_level), 16'(m_lvl));
      chk("rnd_rd", n, 16'(bus_data_out), 16'(m_read(int'(bus_address_in))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller between the peripheral interrupt strobes (the timer `irqs` outputs and other sources) and the CPU. It latches 16 interrupt sources into pending flags and gates them with per-source enables and per-group priorities. It then arbitrates them against the CPU's current interrupt level and presents one frozen request/vector to the CPU with a request/acknowledge handshake. All registers are CPU-visible on the system bus.

## Interface
- `IRQ_PRI`, default 24'h2020: group priority register address (byte).
- `IRQ_ENA`, default 24'h2023: enable register base; `_L` = base, `_H` = base+1.
- `IRQ_ACT`, default 24'h2027: pending flag register base; `_L` = base, `_H` = base+1.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `clk_ce_cpu`  in  1  CPU clock enable; every state update is gated by it.
- `bus_write`  in  1  write strobe, sampled on `clk_ce_cpu` edges.
- `bus_read`  in  1  read strobe; unused, reads are combinational.
- `bus_address_in`  in  24  byte address.
- `bus_data_in`  in  8  write data.
- `bus_data_out`  out  8  combinational read data; 0 for unmapped addresses.
- `irq_in`  in  16  source strobes; bit i is sampled high on a `clk_ce_cpu` edge and sets pending[i].
- `cpu_level`  in  2  current CPU interrupt mask level (0..3).
- `irq_ack`  in  1  CPU acknowledge, one `clk_ce_cpu` cycle.
- `irq_req`  out  1  interrupt request to the CPU.
- `irq_vector`  out  4  source index of the request.
- `irq_level`  out  2  group priority of the request.

## Operation
- Sources are split into 4 groups: group g = sources 4g..4g+3. `IRQ_PRI[2g+1:2g]` is the priority of group g; priority 0 disables the group.
- pending[i] is set on any `irq_in[i]` strobe, independent of the enable and priority settings.
- pending[i] is cleared only by a write of 1 to its bit at `IRQ_ACT_L`/`_H`. Writing 0 to a bit has no effect.
- If a set strobe and a write-1 clear land on the same edge, set wins.
- `IRQ_ENA_L`/`_H` hold enable[15:0], read/write. `IRQ_PRI` is read/write. Reads of `IRQ_ACT` return pending[15:0].
- Eligibility: source i is eligible when pending[i], enable[i] and pri(group(i)) > `cpu_level` all hold.
- Winner selection: highest group priority wins. Ties between groups go to the lower group index. Within a group, the lower source index wins.
- FSM states are IDLE, REQ and HOLD:
  - IDLE: if any source is eligible, capture the winner into `irq_vector`/`irq_level`, assert `irq_req` and go to REQ.
  - REQ: `irq_vector`/`irq_level` stay frozen and are not re-arbitrated, even if a higher-priority source becomes eligible.
  - REQ, `irq_ack`: go to HOLD and deassert `irq_req`.
  - REQ, withdrawal: if the frozen source stops being eligible (flag cleared, enable dropped, group priority lowered, or `cpu_level` raised) and `irq_ack` is low, deassert `irq_req` and return to IDLE. If `irq_ack` and loss of eligibility coincide, the ack wins and the FSM goes to HOLD.
  - HOLD: lasts exactly one `clk_ce_cpu` cycle so that `cpu_level` can update, then returns to IDLE.
- `irq_ack` outside REQ is ignored.
- Hardware never clears pending flags. Software clears them in the handler.

## Timing
- Reset values: all registers 0, state IDLE, `irq_req`=0, `irq_vector`=0, `irq_level`=0.
- Reset mid-request drops `irq_req` on the same edge.
- Latency: an `irq_in` strobe on ce edge k sets pending at k. With the source eligible, `irq_req` is high after ce edge k+1.
- A register write on ce edge k affects arbitration from edge k+1.
- After `irq_ack` on edge k, `irq_req` is low after k. The earliest reassertion is after edge k+2.
- Non-ce clk edges change nothing.
- Arbitration is combinational from registered state. `bus_data_out` follows the address combinationally.

## Test plan
- Basic request: PRI=8'h03, ENA_L=8'h01, `cpu_level`=0, pulse `irq_in[0]` -> `irq_req`=1, vector 0, level 3 after 2 ce edges. ACT_L reads 8'h01. Write ACT_L=8'h01 -> reads 8'h00.
- Priority arbitration: PRI=8'b01_11_10_01 (g0=1, g1=2, g2=3, g3=1), all enabled, pulse sources 1, 5, 9, 13 together -> vector 9, level 3. Clear 9 after ack -> next vector 5, then 1, then 13.
- Masking: group priority 2 with `cpu_level`=2 -> no request. Drop `cpu_level` to 1 -> request asserts next ce edge.
- Enable off: ENA=0, pulse `irq_in[7]` -> pending[7]=1, `irq_req`=0. Set ENA_L bit 7 -> request vector 7.
- Withdrawal: in REQ for source 3, software clears ACT bit 3 -> `irq_req` falls one edge later with no ack. Clear and set on the same edge -> flag stays 1.
- Handshake/HOLD: ack on edge k with the pending flag still set and `cpu_level` unchanged -> `irq_req` low at k+1, high again at k+2. Reset while in REQ -> all outputs 0.
